// File: rtl/bf_pkg.sv
// Shared encodings for the Brainfuck CPU: opcodes, fetch-stage states and fault causes.
// Imported by the fetch unit, the ROM generator and the execute stage.
package bf_pkg;

    typedef enum logic [2:0] {
        OP_IN   = 3'b000,
        OP_OUT  = 3'b001,
        OP_BACK = 3'b010,
        OP_IF   = 3'b011,
        OP_MOVL = 3'b100,
        OP_MOVR = 3'b101,
        OP_DEC  = 3'b110,
        OP_INC  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKIP = 2'd1,
        ST_HALT = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_OVERFLOW   = 2'd1,
        ERR_EMPTY_BACK = 2'd2,
        ERR_UNMATCHED  = 2'd3
    } err_code_t;

endpackage

// File: rtl/bf_fetch_unit_if.sv
// ROM and execute-stage signals of the fetch unit, bundled as one interface.
interface bf_fetch_unit_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] rom_addr;
    logic [2:0]        rom_code;
    logic              rom_overrun;
    logic              instr_valid;
    logic [2:0]        instr_code;
    logic              instr_ready;
    logic              exec_busy;
    logic              cell_zero;

    // Handshake: an opcode transfers in a cycle where instr_valid and instr_ready are both
    // high; while valid is high and ready low, instr_code holds and valid stays high.
    modport master (
        output rom_addr, instr_valid, instr_code,
        input  rom_code, rom_overrun, instr_ready, exec_busy, cell_zero
    );

    modport slave (
        input  rom_addr, instr_valid, instr_code,
        output rom_code, rom_overrun, instr_ready, exec_busy, cell_zero
    );
endinterface

// File: rtl/bf_loop_stack.sv
// Loop-return LIFO: synchronous push/pop, combinational top-of-stack read.
module bf_loop_stack #(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 16,
    parameter int SP_W        = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty,
    output logic [SP_W-1:0]   sp
);
    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp_m1;

    assign full  = (sp == SP_W'(STACK_DEPTH));
    assign empty = (sp == '0);
    assign sp_m1 = sp - 1'b1;
    assign top   = mem[sp_m1[SP_W-2:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    // Storage needs no reset; only entries below sp are ever read meaningfully.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[SP_W-2:0]] <= push_data;
        end
    end
endmodule

// File: rtl/bf_fetch_unit.sv
// Program counter and control flow for the Brainfuck CPU: resolves [ and ] locally and
// offers every other opcode to the execute stage.
module bf_fetch_unit
    import bf_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    bf_fetch_unit_if.master               bus,
    output logic                          halted,
    output logic                          error,
    output logic [1:0]                    err_code,
    output fetch_state_t                  state_dbg,
    output logic [$clog2(STACK_DEPTH):0]  sp_dbg
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    fetch_state_t      state;
    err_code_t         err_q;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] depth;
    logic [ADDR_W-1:0] depth_dec;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stk_top;
    logic [SP_W-1:0]   sp;
    logic              stk_full;
    logic              stk_empty;
    logic              is_if;
    logic              is_back;
    logic              resolve;
    logic              push;
    logic              pop;

    assign is_if     = (bus.rom_code == OP_IF);
    assign is_back   = (bus.rom_code == OP_BACK);
    assign pc_inc    = pc + 1'b1;
    assign depth_dec = depth - 1'b1;

    // A bracket in RUN is acted on only in a cycle where the execute stage is idle,
    // because cell_zero is meaningful only then.
    assign resolve = run && (state == ST_RUN) && !bus.rom_overrun && !bus.exec_busy;
    assign push    = resolve && is_if && !bus.cell_zero && !stk_full;
    assign pop     = resolve && is_back && bus.cell_zero && !stk_empty;

    assign bus.rom_addr    = pc;
    assign bus.instr_code  = bus.rom_code;
    assign bus.instr_valid = !rst && run && (state == ST_RUN) && !bus.rom_overrun
                             && !is_if && !is_back;

    assign err_code  = err_q;
    assign state_dbg = state;
    assign sp_dbg    = sp;

    bf_loop_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .SP_W        (SP_W)
    ) u_loop_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .sp        (sp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            pc     <= '0;
            depth  <= '0;
            halted <= 1'b0;
            error  <= 1'b0;
            err_q  <= ERR_NONE;
        end else if (run) begin
            case (state)
                ST_RUN: begin
                    if (bus.rom_overrun) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else if (is_if || is_back) begin
                        if (!bus.exec_busy) begin
                            if (is_if && !bus.cell_zero) begin
                                if (stk_full) begin
                                    state <= ST_ERR;
                                    error <= 1'b1;
                                    err_q <= ERR_OVERFLOW;
                                end else begin
                                    pc <= pc_inc;
                                end
                            end else if (is_if) begin
                                depth <= ADDR_W'(1);
                                pc    <= pc_inc;
                                state <= ST_SKIP;
                            end else if (stk_empty) begin
                                state <= ST_ERR;
                                error <= 1'b1;
                                err_q <= ERR_EMPTY_BACK;
                            end else if (!bus.cell_zero) begin
                                pc <= stk_top;
                            end else begin
                                pc <= pc_inc;
                            end
                        end
                    end else if (bus.instr_ready) begin
                        pc <= pc_inc;
                    end
                end
                ST_SKIP: begin
                    if (bus.rom_overrun) begin
                        state <= ST_ERR;
                        error <= 1'b1;
                        err_q <= ERR_UNMATCHED;
                    end else begin
                        pc <= pc_inc;
                        if (is_if) begin
                            depth <= depth + 1'b1;
                        end else if (is_back) begin
                            depth <= depth_dec;
                            if (depth_dec == '0) begin
                                state <= ST_RUN;
                            end
                        end
                    end
                end
                default: begin
                    // HALT and ERR hold everything until reset.
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bf_fetch_unit.sv
// Directed bench for bf_fetch_unit: behavioural ROM, hand-computed expected values per cycle.
module tb_bf_fetch_unit;
    import bf_pkg::*;

    logic         clk;
    logic         rst;
    logic         run;
    logic         halted;
    logic         error;
    logic [1:0]   err_code;
    fetch_state_t state_dbg;
    logic [4:0]   sp_dbg;

    logic [2:0]   prog [64];
    int           prog_len;
    int           checks;
    int           failures;
    int           dec_seen;

    bf_fetch_unit_if #(.ADDR_W(10)) bus ();

    bf_fetch_unit #(
        .ADDR_W      (10),
        .STACK_DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .bus       (bus),
        .halted    (halted),
        .error     (error),
        .err_code  (err_code),
        .state_dbg (state_dbg),
        .sp_dbg    (sp_dbg)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational ROM model
    always_comb begin
        if (int'(bus.rom_addr) >= prog_len) begin
            bus.rom_overrun = 1'b1;
            bus.rom_code    = 3'b000;
        end else begin
            bus.rom_overrun = 1'b0;
            bus.rom_code    = prog[bus.rom_addr[5:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input string s);
        for (int i = 0; i < 64; i++) prog[i] = 3'b000;
        prog_len = s.len();
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "+":     prog[i] = 3'b111;
                "-":     prog[i] = 3'b110;
                ">":     prog[i] = 3'b101;
                "<":     prog[i] = 3'b100;
                "[":     prog[i] = 3'b011;
                "]":     prog[i] = 3'b010;
                ".":     prog[i] = 3'b001;
                default: prog[i] = 3'b000;
            endcase
        end
    endtask

    task automatic drive(input logic rdy, input logic busy, input logic cz);
        bus.instr_ready = rdy;
        bus.exec_busy   = busy;
        bus.cell_zero   = cz;
    endtask

    // Ends half-way into cycle 0 after release, inputs applied, ready for checks.
    task automatic do_reset(input string s, input logic rdy, input logic busy, input logic cz);
        rst = 1'b1;
        run = 1'b1;
        load(s);
        drive(rdy, busy, cz);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    // Advance one cycle: inputs change 2 units after the edge, checks follow 1 unit later.
    task automatic cyc(input logic rdy, input logic busy, input logic cz);
        @(posedge clk);
        #2 drive(rdy, busy, cz);
        #1;
    endtask

    logic [2:0] t1_exp [4];
    logic       t4_busy [10];
    logic       t4_cz [10];
    int         t4_pc [10];
    int         t4_sp [10];

    initial begin
        checks   = 0;
        failures = 0;
        prog_len = 0;
        rst      = 1'b1;
        run      = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        t1_exp = '{3'b111, 3'b001, 3'b101, 3'b110};

        // Reset state, checked while rst is still asserted
        load("+.>-");
        run = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("rst_pc", 32'(bus.rom_addr), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_RUN));
        check("rst_valid", 32'(bus.instr_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_error", 32'(error), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_sp", 32'(sp_dbg), 0);

        // +.>- at full throughput
        do_reset("+.>-", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t1_valid", 32'(bus.instr_valid), 1);
            check("t1_code", 32'(bus.instr_code), 32'(t1_exp[i]));
            check("t1_pc", 32'(bus.rom_addr), 32'(i));
            cyc(1'b1, 1'b0, 1'b0);
        end
        check("t1_valid_end", 32'(bus.instr_valid), 0);
        check("t1_halted_early", 32'(halted), 0);
        cyc(1'b1, 1'b0, 1'b0);
        check("t1_halted", 32'(halted), 1);
        check("t1_state", 32'(state_dbg), 32'(ST_HALT));
        cyc(1'b1, 1'b0, 1'b0);
        check("t1_pc_frozen", 32'(bus.rom_addr), 4);

        // instr_ready low on cycles 1-2
        do_reset("+.>-", 1'b1, 1'b0, 1'b0);
        check("t2_c0_code", 32'(bus.instr_code), 3'b111);
        cyc(1'b0, 1'b0, 1'b0);
        check("t2_c1_code", 32'(bus.instr_code), 3'b001);
        cyc(1'b0, 1'b0, 1'b0);
        check("t2_c2_code", 32'(bus.instr_code), 3'b001);
        check("t2_c2_valid", 32'(bus.instr_valid), 1);
        check("t2_c2_pc", 32'(bus.rom_addr), 1);
        cyc(1'b1, 1'b0, 1'b0);
        check("t2_c3_code", 32'(bus.instr_code), 3'b001);
        cyc(1'b1, 1'b0, 1'b0);
        check("t2_c4_code", 32'(bus.instr_code), 3'b101);
        cyc(1'b1, 1'b0, 1'b0);
        check("t2_c5_code", 32'(bus.instr_code), 3'b110);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("t2_halted", 32'(halted), 1);

        // run low freezes the stage and hides the offer
        do_reset("+.>-", 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        run = 1'b0;
        #1;
        check("frz_valid", 32'(bus.instr_valid), 0);
        cyc(1'b1, 1'b0, 1'b0);
        check("frz_pc", 32'(bus.rom_addr), 1);
        run = 1'b1;
        #1;
        check("frz_resume_code", 32'(bus.instr_code), 3'b001);

        // [+] with cell_zero=1 skips the body
        do_reset("[+]", 1'b1, 1'b0, 1'b1);
        check("t3_c0_valid", 32'(bus.instr_valid), 0);
        cyc(1'b1, 1'b0, 1'b1);
        check("t3_c1_state", 32'(state_dbg), 32'(ST_SKIP));
        check("t3_c1_pc", 32'(bus.rom_addr), 1);
        check("t3_c1_valid", 32'(bus.instr_valid), 0);
        cyc(1'b1, 1'b0, 1'b1);
        check("t3_c2_pc", 32'(bus.rom_addr), 2);
        check("t3_c2_valid", 32'(bus.instr_valid), 0);
        cyc(1'b1, 1'b0, 1'b1);
        check("t3_c3_state", 32'(state_dbg), 32'(ST_RUN));
        check("t3_c3_pc", 32'(bus.rom_addr), 3);
        cyc(1'b1, 1'b0, 1'b1);
        check("t3_halted", 32'(halted), 1);

        // +[-] loops twice more, then falls through; one BACK waits on exec_busy
        t4_busy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t4_cz   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t4_pc   = '{0, 1, 2, 3, 3, 2, 3, 2, 3, 4};
        t4_sp   = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        dec_seen = 0;
        do_reset("+[-]", 1'b1, t4_busy[0], t4_cz[0]);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc(1'b1, t4_busy[i], t4_cz[i]);
            check("t4_pc", 32'(bus.rom_addr), 32'(t4_pc[i]));
            check("t4_sp", 32'(sp_dbg), 32'(t4_sp[i]));
            if (bus.instr_valid && bus.instr_code == 3'b110) dec_seen++;
        end
        check("t4_dec_count", 32'(dec_seen), 3);
        cyc(1'b1, 1'b0, 1'b0);
        check("t4_halted", 32'(halted), 1);

        // ] with empty stack
        do_reset("]", 1'b1, 1'b0, 1'b0);
        check("t5_error_early", 32'(error), 0);
        cyc(1'b1, 1'b0, 1'b0);
        check("t5_error", 32'(error), 1);
        check("t5_err_code", 32'(err_code), 2);
        check("t5_state", 32'(state_dbg), 32'(ST_ERR));
        cyc(1'b1, 1'b0, 1'b0);
        check("t5_pc_frozen", 32'(bus.rom_addr), 0);
        check("t5_halted", 32'(halted), 0);

        // [[ with cell_zero=1 runs off the end while skipping
        do_reset("[[", 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        check("t6_pc", 32'(bus.rom_addr), 2);
        check("t6_error_early", 32'(error), 0);
        cyc(1'b1, 1'b0, 1'b1);
        check("t6_err_code", 32'(err_code), 3);
        check("t6_error", 32'(error), 1);

        // 17 nested [ with cell_zero=0 overflow the 16-entry stack
        do_reset("[[[[[[[[[[[[[[[[[", 1'b1, 1'b0, 1'b0);
        repeat (16) cyc(1'b1, 1'b0, 1'b0);
        check("t7_sp_full", 32'(sp_dbg), 16);
        check("t7_pc", 32'(bus.rom_addr), 16);
        check("t7_error_early", 32'(error), 0);
        cyc(1'b1, 1'b0, 1'b0);
        check("t7_err_code", 32'(err_code), 1);
        check("t7_sp_held", 32'(sp_dbg), 16);
        cyc(1'b1, 1'b0, 1'b0);
        check("t7_pc_frozen", 32'(bus.rom_addr), 16);

        // Reset asserted mid-skip at depth 2
        do_reset("+[[+]]", 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        check("t8_pre_state", 32'(state_dbg), 32'(ST_SKIP));
        check("t8_pre_pc", 32'(bus.rom_addr), 3);
        rst = 1'b1;
        #1;
        check("t8_rst_pc", 32'(bus.rom_addr), 0);
        check("t8_rst_state", 32'(state_dbg), 32'(ST_RUN));
        check("t8_rst_sp", 32'(sp_dbg), 0);
        check("t8_rst_valid", 32'(bus.instr_valid), 0);
        cyc(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check("t8_resume_valid", 32'(bus.instr_valid), 1);
        check("t8_resume_code", 32'(bus.instr_code), 3'b111);
        cyc(1'b1, 1'b0, 1'b1);
        check("t8_resume_pc", 32'(bus.rom_addr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
